// File: rtl/block_transfer_ctrl_pkg.sv
// Shared state encoding and constants for the block transfer controller.
package block_transfer_ctrl_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
endpackage

// File: rtl/block_transfer_ctrl_reg_list_encoder.sv
// Register-list encoder: lowest set bit, any-set flag and population count.
module reg_list_encoder #(
  parameter  int NREG = 16,
  localparam int IW   = $clog2(NREG)
) (
  input  logic [NREG-1:0] i_list,
  output logic [IW-1:0]   o_low,
  output logic            o_any,
  output logic [IW:0]     o_count
);
  always_comb begin
    o_low   = '0;
    o_count = '0;
    // Descending scan so the last hit is the lowest index.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (i_list[i]) o_low = IW'(i);
      o_count = o_count + (IW + 1)'(i_list[i]);
    end
    o_any = |i_list;
  end
endmodule

// File: rtl/block_transfer_ctrl.sv
// LDM/STM block transfer sequencer: walks a register list against memory,
// then optionally writes the updated base register back.
module block_transfer_ctrl
  import block_transfer_ctrl_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = 16,
  localparam int IW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load,
  input  logic [NREG-1:0]   reg_list,
  input  logic [IW-1:0]     base_reg,
  input  logic [DATA_W-1:0] base_addr,
  input  logic              up,
  input  logic              pre,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [IW-1:0]     rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data,
  output logic [IW-1:0]     rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_write_reg,
  output logic              rf_write_pc,
  output logic [DATA_W-1:0] rf_pc_data
);
  localparam logic [IW-1:0]     PC_IDX = IW'(NREG - 1);
  localparam logic [DATA_W-1:0] STEP   = DATA_W'(WORD_BYTES);

  state_t              r_state, w_next;
  logic [NREG-1:0]     r_pending;
  logic [DATA_W-1:0]   r_addr, r_final;
  logic [IW-1:0]       r_base_reg;
  logic                r_load, r_wb_do;

  logic [NREG-1:0]     w_enc_in, w_pend_next;
  logic [IW-1:0]       w_low;
  logic                w_any;
  logic [IW:0]         w_cnt;
  logic [DATA_W-1:0]   w_span, w_first, w_final;

  // One encoder serves both phases: the request list in IDLE, pending in XFER.
  assign w_enc_in = (r_state == IDLE) ? reg_list : r_pending;

  reg_list_encoder #(.NREG(NREG)) u_enc (
    .i_list  (w_enc_in),
    .o_low   (w_low),
    .o_any   (w_any),
    .o_count (w_cnt)
  );

  assign w_pend_next = r_pending & ~(NREG'(1) << w_low);
  assign w_span      = DATA_W'(w_cnt) * STEP;
  assign w_final     = up ? base_addr + w_span : base_addr - w_span;

  always_comb begin
    case ({up, pre})
      2'b10:   w_first = base_addr;
      2'b11:   w_first = base_addr + STEP;
      2'b00:   w_first = base_addr - w_span + STEP;
      default: w_first = base_addr - w_span;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= '0;
      r_addr     <= '0;
      r_final    <= '0;
      r_base_reg <= '0;
      r_load     <= 1'b0;
      r_wb_do    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_pending  <= reg_list;
          r_addr     <= w_first;
          r_final    <= w_final;
          r_base_reg <= base_reg;
          r_load     <= load;
          // A loaded base register overrides the computed writeback.
          r_wb_do    <= wb_en && !(load && reg_list[base_reg]);
        end
        XFER: if (mem_ack) begin
          r_pending <= w_pend_next;
          r_addr    <= r_addr + STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rf_r_addr    = '0;
    rf_w_addr    = '0;
    rf_w_data    = '0;
    rf_write_reg = 1'b0;
    rf_write_pc  = 1'b0;
    rf_pc_data   = '0;
    case (r_state)
      IDLE: if (start) w_next = w_any ? XFER : DONE;
      XFER: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = !r_load;
        mem_addr  = r_addr;
        rf_r_addr = w_low;
        mem_wdata = r_load ? '0 : rf_r_data;
        if (mem_ack) begin
          if (r_load) begin
            if (w_low == PC_IDX) begin
              rf_write_pc = 1'b1;
              rf_pc_data  = mem_rdata;
            end else begin
              rf_write_reg = 1'b1;
              rf_w_addr    = w_low;
              rf_w_data    = mem_rdata;
            end
          end
          if (w_pend_next == '0) w_next = r_wb_do ? WB : DONE;
        end
      end
      WB: begin
        busy         = 1'b1;
        rf_write_reg = 1'b1;
        rf_w_addr    = r_base_reg;
        rf_w_data    = r_final;
        w_next       = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_block_transfer_ctrl.sv
// Randomized bench for block_transfer_ctrl: a transaction-level model sets the
// expected outputs for each cycle and one negedge process compares them.
module tb_block_transfer_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, load, up, pre, wb_en, mem_ack;
  logic [15:0] reg_list;
  logic [3:0]  base_reg, rf_r_addr, rf_w_addr;
  logic [31:0] base_addr, mem_rdata, rf_r_data, mem_addr, mem_wdata, rf_w_data, rf_pc_data;
  logic        busy, done, mem_req, mem_we, rf_write_reg, rf_write_pc;

  logic [31:0] regs_tb [16];
  assign rf_r_data = regs_tb[rf_r_addr];

  block_transfer_ctrl #(.DATA_W(32), .NREG(16)) dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .reg_list(reg_list),
    .base_reg(base_reg), .base_addr(base_addr), .up(up), .pre(pre), .wb_en(wb_en),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .rf_write_reg(rf_write_reg), .rf_write_pc(rf_write_pc),
    .rf_pc_data(rf_pc_data)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, start_cyc = 0, done_cyc = -1;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  bit          e_busy, e_done, e_req, e_we, e_store, e_wr, e_pc, e_zero;
  logic [31:0] e_addr, e_wdata, e_rfwdata, e_pcdata;
  logic [3:0]  e_raddr, e_waddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] first_addr(logic [31:0] b, int n, bit u, bit p);
    logic [31:0] span = 32'(n) * 32'd4;
    if (u) return p ? b + 32'd4 : b;
    return p ? b - span : b - span + 32'd4;
  endfunction

  function automatic logic [31:0] final_base(logic [31:0] b, int n, bit u);
    return u ? b + 32'(n) * 32'd4 : b - 32'(n) * 32'd4;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (chk_en) begin
    if (done) done_cyc <= cyc;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_req", mem_req, e_req);
    chk("rf_write_reg", rf_write_reg, e_wr);
    chk("rf_write_pc", rf_write_pc, e_pc);
    if (e_req) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
    end
    if (e_store) begin
      chk("rf_r_addr", rf_r_addr, e_raddr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (e_wr) begin
      chk("rf_w_addr", rf_w_addr, e_waddr);
      chk("rf_w_data", rf_w_data, e_rfwdata);
    end
    if (e_pc) chk("rf_pc_data", rf_pc_data, e_pcdata);
    if (e_zero) begin
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rf_r_addr", rf_r_addr, 0);
      chk("rst_rf_w_addr", rf_w_addr, 0);
      chk("rst_rf_w_data", rf_w_data, 0);
      chk("rst_rf_pc_data", rf_pc_data, 0);
    end
  end

  task automatic clear_exp();
    {e_busy, e_done, e_req, e_we, e_store, e_wr, e_pc, e_zero} = '0;
    e_addr = '0; e_wdata = '0; e_rfwdata = '0; e_pcdata = '0; e_raddr = '0; e_waddr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input bit noise);
    if (noise) begin
      start     = 1'($urandom_range(0, 1));
      load      = 1'($urandom_range(0, 1));
      reg_list  = 16'($urandom);
      base_reg  = 4'($urandom);
      base_addr = $urandom;
      up        = 1'($urandom_range(0, 1));
      pre       = 1'($urandom_range(0, 1));
      wb_en     = 1'($urandom_range(0, 1));
    end
  endtask

  // One complete transfer; entered and left in IDLE at posedge+1.
  task automatic xfer(input bit ld, input logic [15:0] lst, input logic [3:0] br,
                      input logic [31:0] base, input bit u, input bit p, input bit wb,
                      input int mind, input int maxd, input bit noise);
    int n = $countones(lst);
    logic [31:0] a = first_addr(base, n, u, p);
    bit wbdo = wb && !(ld && lst[br]) && (lst != 0);
    clear_exp();
    start = 1'b1; load = ld; reg_list = lst; base_reg = br; base_addr = base;
    up = u; pre = p; wb_en = wb; mem_ack = 1'b0;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int r = 0; r < 16; r++) if (lst[r]) begin
      int d = $urandom_range(mind, maxd);
      for (int c = 0; c <= d; c++) begin
        clear_exp();
        e_busy = 1; e_req = 1; e_we = !ld; e_addr = a;
        if (!ld) begin e_store = 1; e_raddr = 4'(r); e_wdata = regs_tb[r]; end
        mem_ack = (c == d);
        mem_rdata = $urandom;
        if (ld && c == d) begin
          if (r == 15) begin e_pc = 1; e_pcdata = mem_rdata; end
          else begin e_wr = 1; e_waddr = 4'(r); e_rfwdata = mem_rdata; end
        end
        scramble(noise);
        step();
      end
      a += 32'd4;
    end
    mem_ack = 1'b0;
    if (wbdo) begin
      clear_exp();
      e_busy = 1; e_wr = 1; e_waddr = br; e_rfwdata = final_base(base, n, u);
      scramble(noise);
      step();
    end
    clear_exp();
    e_busy = 1; e_done = 1;
    scramble(noise);
    step();
    clear_exp();
    start = 1'b0;
  endtask

  initial begin
    foreach (regs_tb[i]) regs_tb[i] = $urandom;
    rst = 1'b1; start = 0; load = 0; reg_list = 0; base_reg = 0; base_addr = 0;
    up = 0; pre = 0; wb_en = 0; mem_ack = 0; mem_rdata = 0;
    clear_exp();
    e_zero = 1;
    chk_en = 1;
    repeat (3) step();
    rst = 1'b0;
    step();
    e_zero = 0;

    // Model pins against hand-computed addresses.
    chk("model_first_stm", first_addr(32'h100, 3, 1, 0), 32'h100);
    chk("model_final_stm", final_base(32'h100, 3, 1), 32'h10C);
    chk("model_first_ldm", first_addr(32'h200, 2, 0, 1), 32'h1F8);

    // STM R1-R3 up/post with writeback, ack every cycle.
    xfer(0, 16'h000E, 4'd13, 32'h100, 1, 0, 1, 0, 0, 0);
    chk("done_latency_stm", 32'(done_cyc - start_cyc), 5);

    // LDM R0,R15 down/pre, ack after two wait cycles.
    xfer(1, 16'h8001, 4'd5, 32'h200, 0, 1, 0, 2, 2, 0);

    // LDM into the base register itself: writeback suppressed.
    xfer(1, 16'h0004, 4'd2, 32'h300, 1, 0, 1, 0, 1, 0);

    // Empty list.
    xfer(0, 16'h0000, 4'd1, 32'h500, 1, 0, 1, 0, 0, 0);
    chk("done_latency_empty", 32'(done_cyc - start_cyc), 1);

    // Reset mid-transfer with a late ack.
    clear_exp();
    start = 1; load = 1; reg_list = 16'h00F0; base_reg = 0; base_addr = 32'h400;
    up = 1; pre = 0; wb_en = 1;
    step();
    start = 0;
    repeat (2) begin
      clear_exp();
      e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h404 - 32'd4;
      step();
    end
    rst = 1'b1;
    clear_exp();
    e_zero = 1;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    step();
    rst = 1'b0;
    repeat (2) step();
    mem_ack = 1'b0;
    e_zero = 0;
    xfer(0, 16'h0030, 4'd1, 32'h600, 0, 0, 1, 0, 1, 0);

    // start and other request inputs toggling while busy.
    xfer(1, 16'h1234, 4'd3, 32'h800, 1, 1, 1, 0, 2, 1);

    for (int k = 0; k < 60; k++) begin
      logic [15:0] l = 16'($urandom);
      if (k % 10 == 0) l = 16'h0;
      xfer(1'($urandom_range(0, 1)), l, 4'($urandom), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
